// File: rtl/bw_mult_arbiter_if.sv
// Request/result bus of bw_mult_arbiter: per-requester valid/ready with packed
// operands, plus the single product channel back to the consumer.
interface bw_mult_arbiter_if #(
  parameter int numBit = 16,
  parameter int numReq = 4,
  parameter int idBit  = 2
);
  logic [numReq-1:0]        req_valid_in;
  logic [numReq-1:0]        req_ready_out;
  logic [numReq*numBit-1:0] req_m_in;
  logic [numReq*numBit-1:0] req_n_in;
  logic                     res_valid_out;
  logic                     res_ready_in;
  logic [2*numBit-1:0]      res_out;
  logic [idBit-1:0]         res_id_out;
  logic                     busy_out;

  modport master (
    output req_valid_in, req_m_in, req_n_in, res_ready_in,
    input  req_ready_out, res_valid_out, res_out, res_id_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_m_in, req_n_in, res_ready_in,
    output req_ready_out, res_valid_out, res_out, res_id_out, busy_out
  );
endinterface

// File: rtl/bw_mult_arbiter.sv
// Round-robin arbiter sharing one Baugh-Wooley signed multiplier among numReq clients.
// Optional macro BW_ARB_PERF_EN adds a saturating 16-bit accepted-result counter (op_count_out).
module bw_mult_arbiter #(
  parameter int numBit = 16,
  parameter int numReq = 4,
  parameter int idBit  = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  bw_mult_arbiter_if.slave bus
`ifdef BW_ARB_PERF_EN
  ,
  output logic [15:0] op_count_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2*numBit-1:0] ONE_W    = {{(2*numBit-1){1'b0}}, 1'b1};
  localparam logic [2*numBit-1:0] BW_CONST = (ONE_W << numBit) | (ONE_W << (2*numBit-1));

  // Baugh-Wooley: sign-row/column cross terms are inverted and the correction
  // constant 2^n + 2^(2n-1) restores the two's-complement result.
  function automatic logic [2*numBit-1:0] bw_mult(input logic [numBit-1:0] a,
                                                  input logic [numBit-1:0] b);
    logic [2*numBit-1:0] acc;
    logic [2*numBit-1:0] row;
    acc = BW_CONST;
    for (int i = 0; i < numBit; i++) begin
      row = '0;
      for (int j = 0; j < numBit; j++) begin
        if ((i == numBit-1) != (j == numBit-1)) begin
          row[i+j] = ~(a[i] & b[j]);
        end else begin
          row[i+j] = a[i] & b[j];
        end
      end
      acc = acc + row;
    end
    return acc;
  endfunction

  state_t              state_r;
  logic [idBit-1:0]    rr_ptr_r;
  logic [idBit-1:0]    op_id_r;
  logic [numBit-1:0]   op_m_r;
  logic [numBit-1:0]   op_n_r;
  logic [2*numBit-1:0] res_r;
  logic [idBit-1:0]    res_id_r;
  logic                res_valid_r;

  logic                grant_vld_s;
  logic [idBit-1:0]    grant_id_s;
  logic [idBit-1:0]    next_ptr_s;
  logic [idBit-1:0]    idx_s;
  logic [idBit:0]      sum_s;
  logic [numReq-1:0]   ready_s;
  logic [numBit-1:0]   sel_m_s;
  logic [numBit-1:0]   sel_n_s;
  logic [2*numBit-1:0] product_s;

  // Round-robin winner search starting at rr_ptr_r, wrapping modulo numReq
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    sum_s       = '0;
    idx_s       = '0;
    for (int k = 0; k < numReq; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (idBit+1)'(k);
      if (sum_s >= (idBit+1)'(numReq)) begin
        idx_s = idBit'(sum_s - (idBit+1)'(numReq));
      end else begin
        idx_s = sum_s[idBit-1:0];
      end
      if (!grant_vld_s && bus.req_valid_in[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Grant decode, operand mux for the winner and pointer advance
  always_comb begin
    ready_s = '0;
    sel_m_s = '0;
    sel_n_s = '0;
    if (state_r == ST_IDLE && grant_vld_s && rst_n_in) begin
      ready_s[grant_id_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
    for (int k = 0; k < numReq; k++) begin
      if (grant_id_s == idBit'(k)) begin
        sel_m_s = bus.req_m_in[k*numBit +: numBit];
        sel_n_s = bus.req_n_in[k*numBit +: numBit];
      end else begin
        sel_m_s = sel_m_s;
      end
    end
    if (grant_id_s == idBit'(numReq-1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id_s + idBit'(1);
    end
  end

  assign product_s = bw_mult(op_m_r, op_n_r);

  // Control FSM with operand, product and id registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      op_id_r     <= '0;
      op_m_r      <= '0;
      op_n_r      <= '0;
      res_r       <= '0;
      res_id_r    <= '0;
      res_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            op_m_r   <= sel_m_s;
            op_n_r   <= sel_n_s;
            op_id_r  <= grant_id_s;
            rr_ptr_r <= next_ptr_s;
            state_r  <= ST_CALC;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_CALC: begin
          res_r       <= product_s;
          res_id_r    <= op_id_r;
          res_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ready_in) begin
            res_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_out = ready_s;
  assign bus.res_valid_out = res_valid_r;
  assign bus.res_out       = res_r;
  assign bus.res_id_out    = res_id_r;
  assign bus.busy_out      = (state_r != ST_IDLE);

`ifdef BW_ARB_PERF_EN
  logic [15:0] op_count_r;

  // Accepted-result counter, saturating at all-ones
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      op_count_r <= 16'd0;
    end else if (res_valid_r && bus.res_ready_in && (op_count_r != 16'hFFFF)) begin
      op_count_r <= op_count_r + 16'd1;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign op_count_out = op_count_r;
`endif

endmodule

// File: tb/tb_bw_mult_arbiter.sv
// Scoreboard bench for bw_mult_arbiter: directed requests push expected
// products; a monitor pops and compares on every result handshake.
module tb_bw_mult_arbiter;
  localparam int NB = 16;
  localparam int NR = 4;
  localparam int IB = 2;

  typedef struct packed {
    logic [31:0] prod;
    logic [1:0]  id;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*NB-1:0] req_m;
  logic [NR*NB-1:0] req_n;
  logic             res_ready;
  int               pass_cnt = 0;
  int               total_cnt = 0;
  exp_t             sb_q[$];
`ifdef BW_ARB_PERF_EN
  logic [15:0]      op_count;
`endif

  bw_mult_arbiter_if #(.numBit(NB), .numReq(NR), .idBit(IB)) bus ();

  assign bus.req_valid_in = req_valid;
  assign bus.req_m_in     = req_m;
  assign bus.req_n_in     = req_n;
  assign bus.res_ready_in = res_ready;

  bw_mult_arbiter #(.numBit(NB), .numReq(NR), .idBit(IB)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
`ifdef BW_ARB_PERF_EN
    ,
    .op_count_out (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_count(input logic [15:0] exp);
`ifdef BW_ARB_PERF_EN
    check("op_count", 64'(op_count), 64'(exp));
`else
    if (exp == 16'hFFFF) $display("count %0d", exp);
`endif
  endtask

  task automatic issue(input int k, input logic [15:0] m, input logic [15:0] n,
                       input logic [31:0] prod);
    logic got;
    got = 1'b0;
    req_valid[k] = 1'b1;
    req_m[k*NB +: NB] = m;
    req_n[k*NB +: NB] = n;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (bus.req_ready_out[k]) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      check("grant_onehot", 64'(bus.req_ready_out), 64'(4'b0001 << k));
      sb_q.push_back('{prod, 2'(k)});
      @(negedge clk);
      req_valid[k] = 1'b0;
    end else begin
      total_cnt++;
      $display("FAIL grant_timeout: requester %0d saw no ready, expected a grant", k);
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (c < 30 && (sb_q.size() != 0 || bus.busy_out)) begin
      @(negedge clk);
      c++;
    end
    check("drain_queue", 64'(sb_q.size()), 64'd0);
    check("drain_idle", 64'(bus.busy_out), 64'd0);
  endtask

  // Scoreboard monitor: compare on each result handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.res_valid_out && res_ready) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_result: got id %0d prod 0x%0h, expected none",
                   bus.res_id_out, bus.res_out);
        end else begin
          e = sb_q.pop_front();
          check("result_prod", 64'(bus.res_out), 64'(e.prod));
          check("result_id", 64'(bus.res_id_out), 64'(e.id));
        end
      end
    end
  end

  initial begin
    int          order[5];
    logic [31:0] prods[4];
    int          g;
    int          last;
    order = '{0, 1, 2, 3, 0};
    prods = '{32'h0000_0006, 32'hFFFF_FFF2, 32'h0001_0000, 32'h0000_8000};

    rst_n = 1'b0; res_ready = 1'b1; req_valid = '0; req_m = '0; req_n = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", 64'(bus.req_ready_out), 64'd0);
    check("reset_valid", 64'(bus.res_valid_out), 64'd0);
    check("reset_busy", 64'(bus.busy_out), 64'd0);
    check("reset_res", 64'({bus.res_id_out, bus.res_out}), 64'd0);
    check_count(16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request and latency
    @(negedge clk);
    issue(0, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1);
    #1;
    check("calc_busy", 64'(bus.busy_out), 64'd1);
    check("calc_no_valid", 64'(bus.res_valid_out), 64'd0);
    @(negedge clk);
    #1;
    check("done_latency", 64'(bus.res_valid_out), 64'd1);
    wait_drain();
    @(negedge clk);

    // corner products
    issue(1, 16'h8000, 16'h8000, 32'h4000_0000);
    wait_drain(); @(negedge clk);
    issue(2, 16'h7FFF, 16'h8000, 32'hC000_8000);
    wait_drain(); @(negedge clk);
    issue(3, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    wait_drain(); @(negedge clk);

    // all requesters continuously valid from reset
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_m = {16'hFFFF, 16'h0100, 16'hFFFE, 16'h0002};
    req_n = {16'h8000, 16'h0100, 16'h0007, 16'h0003};
    @(negedge clk);
    #1 check_count(16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    g = 0; last = 0;
    for (int c = 0; c < 40 && g < 5; c++) begin
      #1;
      if (bus.req_ready_out != '0) begin
        check("rr_order", 64'(bus.req_ready_out), 64'(4'b0001 << order[g]));
        if (g > 0) check("issue_interval", 64'(c - last), 64'd3);
        last = c;
        sb_q.push_back('{prods[order[g]], 2'(order[g])});
        g++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("rr_grant_count", 64'(g), 64'd5);
    wait_drain();
    check_count(16'd5);
    @(negedge clk);

    // backpressure
    res_ready = 1'b0;
    issue(1, 16'h0010, 16'hFFF0, 32'hFFFF_FF00);
    req_valid[2] = 1'b1;
    req_m[2*NB +: NB] = 16'h0005;
    req_n[2*NB +: NB] = 16'hFFFF;
    #1 check("calc_no_grant", 64'(bus.req_ready_out), 64'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_valid", 64'(bus.res_valid_out), 64'd1);
      check("stall_busy", 64'(bus.busy_out), 64'd1);
      check("stall_no_grant", 64'(bus.req_ready_out), 64'd0);
      check("stall_res", 64'(bus.res_out), 64'hFFFF_FF00);
      check("stall_id", 64'(bus.res_id_out), 64'd1);
      @(negedge clk);
    end
    check_count(16'd5);
    res_ready = 1'b1;
    #1 check("release_no_grant", 64'(bus.req_ready_out), 64'd0);
    @(negedge clk);
    #1;
    check("release_idle", 64'(bus.busy_out), 64'd0);
    check("release_grant", 64'(bus.req_ready_out), 64'b0100);
    sb_q.push_back('{32'hFFFF_FFFB, 2'd2});
    check_count(16'd6);
    @(negedge clk);
    req_valid[2] = 1'b0;
    wait_drain();
    @(negedge clk);

    // reset while requester 2's operation is in CALC
    req_valid[2] = 1'b1;
    req_m[2*NB +: NB] = 16'h0007;
    req_n[2*NB +: NB] = 16'h0009;
    #1 check("pre_reset_grant", 64'(bus.req_ready_out), 64'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    #1 check("pre_reset_calc", 64'(bus.busy_out), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(bus.res_valid_out), 64'd0);
    check("async_busy", 64'(bus.busy_out), 64'd0);
    check("async_ready", 64'(bus.req_ready_out), 64'd0);
    check("async_res", 64'({bus.res_id_out, bus.res_out}), 64'd0);
    check_count(16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    req_m[1*NB +: NB] = 16'h0003;
    req_n[1*NB +: NB] = 16'hFFFB;
    req_m[3*NB +: NB] = 16'h0002;
    req_n[3*NB +: NB] = 16'h0002;
    #1 check("post_reset_ptr", 64'(bus.req_ready_out), 64'b0010);
    sb_q.push_back('{32'hFFFF_FFF1, 2'd1});
    @(negedge clk);
    req_valid = '0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("no_stray_result", 64'(bus.res_valid_out), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
